muldiv_unit: RTL and testbench

Sequential, parametrised multiply/divide unit with architectural HI/LO registers. It is the multi-cycle companion to the datapath ALU and owns all HI/LO state, replacing the single-cycle mult/mthi/mtlo/mfhi/mflo paths. It accepts one operation per start pulse, computes iteratively in WIDTH cycles, and raises busy so the pipeline control stalls any HI/LO reader until done.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_if.sv | 19 +
 rtl/muldiv_step.sv | 41 ++++
 rtl/muldiv_unit.sv | 141 ++++++++++++++
 tb/tb_muldiv_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide unit.
//   - op code constants driven on the op port
//   - FSM state encoding
//   - mag(): two's-complement magnitude of a w-bit value held in a
//     MAX_W-bit container (operand widths up to MAX_W are supported)
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int MAX_W = 64;

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  // Magnitude of the w-bit two's-complement number in v[w-1:0]; bits above
  // w are assumed zero and stay zero. The most negative value maps onto
  // itself, which read as unsigned is exactly its magnitude.
  function automatic logic [MAX_W-1:0] mag(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] mask;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    return v[w-1] ? ((~v + MAX_W'(1)) & mask) : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between pipeline control and muldiv_unit.
//   start/op/a/b : request, driven by the master (pipeline control)
//   busy/done    : status, driven by the slave (muldiv_unit)
//   hi/lo        : architectural HI/LO registers, driven by the slave
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one iteration of the shared multiply/divide datapath.
//   acc      : {upper, lower} accumulator
//              multiply: upper = partial product, lower = remaining multiplier
//              divide  : upper = partial remainder, lower = dividend/quotient
//   opnd     : multiplicand (multiply) or divisor (divide), both unsigned
//   div_mode : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_nxt  : accumulator after this iteration
//   bit_o    : add decision (multiply) or new quotient bit (divide)
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               div_mode,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic               bit_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;

  always_comb begin
    // Multiply: add multiplicand when the current multiplier bit is set,
    // then shift the whole accumulator right by one (carry goes into the top).
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // Divide: shift the next dividend bit into the remainder. rem_sh can be
    // one bit wider than the divisor, but when the trial subtraction succeeds
    // the result is below the divisor, so a WIDTH-bit difference is exact.
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    rem_sub = rem_sh[WIDTH-1:0] - opnd;
    if (div_mode) begin
      bit_o   = (rem_sh >= {1'b0, opnd});
      acc_nxt = {(bit_o ? rem_sub : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], bit_o};
    end else begin
      bit_o   = acc[0];
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit owning the HI/LO registers.
//   clk, rst : clock, synchronous active-high reset
//   bus      : muldiv_if slave port
//              start/op/a/b in; busy/done/hi/lo out (all registered)
// mult/multu/div/divu take WIDTH step cycles and write HI/LO on the last
// step edge; done pulses in the following cycle. mthi/mtlo write directly.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_t             state, state_n;
  logic [CW-1:0]      cnt;
  logic               busy_r, done_r;
  logic [WIDTH-1:0]   hi_r, lo_r;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               div_mode, neg_lo, neg_hi;

  logic               accept, last, is_arith, is_div, is_signed, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc_nxt, prod;
  logic               step_bit;
  logic [WIDTH-1:0]   quo, rem, wb_hi, wb_lo;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .opnd     (opnd),
    .div_mode (div_mode),
    .acc_nxt  (acc_nxt),
    .bit_o    (step_bit)
  );

  // Request decode and operand conditioning
  always_comb begin
    is_arith  = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    is_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    sa        = is_signed & bus.a[WIDTH-1];
    sb        = is_signed & bus.b[WIDTH-1];
    mag_a     = sa ? WIDTH'(mag(MAX_W'(bus.a), WIDTH)) : bus.a;
    mag_b     = sb ? WIDTH'(mag(MAX_W'(bus.b), WIDTH)) : bus.b;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: if (bus.start && is_arith) begin
        accept  = 1'b1;
        state_n = CALC;
      end
      CALC: if (cnt == CW'(WIDTH - 1)) begin
        last    = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Write-back: sign correction applied to the final step's result
  always_comb begin
    prod  = neg_lo ? -acc_nxt : acc_nxt;
    quo   = {acc_nxt[WIDTH-1:1], step_bit};
    quo   = neg_lo ? -quo : quo;
    rem   = neg_hi ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
    wb_hi = div_mode ? rem : prod[2*WIDTH-1:WIDTH];
    wb_lo = div_mode ? quo : prod[WIDTH-1:0];
  end

  // Control and architectural state
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        busy_r <= 1'b1;
        cnt    <= '0;
      end else if (state == CALC) begin
        cnt <= cnt + CW'(1);
        if (last) begin
          cnt    <= '0;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          hi_r   <= wb_hi;
          lo_r   <= wb_lo;
        end
      end else if (bus.start) begin
        if (bus.op == OP_MTHI) hi_r <= bus.a;
        if (bus.op == OP_MTLO) lo_r <= bus.a;
      end
    end
  end

  // Operand latch and iteration accumulator (no reset: only read in CALC).
  // A zero divisor keeps the all-ones quotient unsigned-looking and leaves the
  // remainder equal to the dividend, so quotient negation is suppressed.
  always_ff @(posedge clk) begin
    if (accept) begin
      div_mode <= is_div;
      if (is_div) begin
        acc    <= {{WIDTH{1'b0}}, mag_a};
        opnd   <= mag_b;
        neg_lo <= (sa ^ sb) && (bus.b != '0);
        neg_hi <= sa;
      end else begin
        acc    <= {{WIDTH{1'b0}}, mag_b};
        opnd   <= mag_a;
        neg_lo <= sa ^ sb;
        neg_hi <= 1'b0;
      end
    end else if (state == CALC) begin
      acc <= acc_nxt;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit at WIDTH = 32.
// Directed vector table, hand-written corner sequences (mthi/mtlo, start
// during CALC, reset abort) and random operations against an arithmetic
// reference model.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010,
                         DIVU = 3'b011, MTHI = 3'b100, MTLO = 3'b101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural rules.
  function automatic void ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 output logic [W-1:0] h, output logic [W-1:0] l);
    longint p;
    int sa, sb;
    logic [63:0] pu;
    sa = $signed(a);
    sb = $signed(b);
    h = '0;
    l = '0;
    case (op)
      MULT: begin
        p = longint'(sa) * longint'(sb);
        {h, l} = p;
      end
      MULTU: begin
        pu = {32'd0, a} * {32'd0, b};
        {h, l} = pu;
      end
      DIV: begin
        if (b == 0) begin h = a; l = '1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin h = '0; l = a; end
        else begin l = sa / sb; h = sa % sb; end
      end
      default: begin
        if (b == 0) begin h = a; l = '1; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endfunction

  // Called at #1 after an edge with the unit idle (or in a done cycle).
  // Leaves the bench at #1 in the done cycle.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    logic [W-1:0] oh, ol;
    logic prof_ok;
    prof_ok = 1'b1;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    oh = bus.hi; ol = bus.lo;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    for (int c = 1; c <= W; c++) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.hi !== oh || bus.lo !== ol)
        prof_ok = 1'b0;
      @(posedge clk); #1;
    end
    chk({nm, " busy/hold profile"}, 64'(prof_ok), 64'd1);
    chk({nm, " done"}, 64'(bus.done), 64'd1);
    chk({nm, " busy at done"}, 64'(bus.busy), 64'd0);
    chk({nm, " hi"}, 64'(bus.hi), 64'(eh));
    chk({nm, " lo"}, 64'(bus.lo), 64'(el));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] eh, el, ra, rb, hq, lq;
    logic [2:0]   rop;
    int           dcnt, dcyc;

    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;

    tv[0] = '{MULT,  32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tv[1] = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
    tv[2] = '{MULTU, 32'h0001_0000, 32'h0001_0000,  32'd1,         32'd0};
    tv[3] = '{DIV,   32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tv[4] = '{DIVU,  32'd7,         32'd2,          32'd1,         32'd3};
    tv[5] = '{DIV,   32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF};
    tv[6] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000};
    tv[7] = '{DIV,   32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 32'hFFFF_FFFF};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table; each op after the first starts in the previous done cycle
    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b, tv[i].ehi, tv[i].elo);
    @(posedge clk); #1;
    chk("done drops after pulse", 64'(bus.done), 64'd0);

    // mthi / mtlo on consecutive cycles
    bus.start = 1'b1; bus.op = MTHI; bus.a = 32'h1234;
    @(posedge clk); #1;
    chk("mthi hi", 64'(bus.hi), 64'h1234);
    chk("mthi busy", 64'(bus.busy), 64'd0);
    bus.op = MTLO; bus.a = 32'h5678;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("mtlo lo", 64'(bus.lo), 64'h5678);
    chk("mtlo hi kept", 64'(bus.hi), 64'h1234);
    chk("mtlo busy", 64'(bus.busy), 64'd0);
    chk("mtlo done", 64'(bus.done), 64'd0);

    // Reserved op codes are ignored
    bus.start = 1'b1; bus.op = 3'b110; bus.a = 32'hDEAD;
    @(posedge clk); #1;
    bus.op = 3'b111;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("reserved busy", 64'(bus.busy), 64'd0);
    chk("reserved hi/lo", {bus.hi, bus.lo}, {32'h1234, 32'h5678});

    // Start during CALC is ignored: one done, div result intact
    bus.start = 1'b1; bus.op = DIV; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dcnt = 0; dcyc = 0; hq = '0; lq = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (bus.done === 1'b1) begin
        dcnt++;
        if (dcyc == 0) dcyc = cyc;
        hq = bus.hi; lq = bus.lo;
      end
      if (cyc == 5) begin
        bus.start = 1'b1; bus.op = MULTU; bus.a = 32'hFFFF; bus.b = 32'hFFFF;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("ignored start done count", 64'(dcnt), 64'd1);
    chk("ignored start done cycle", 64'(dcyc), 64'd33);
    chk("ignored start div hi", 64'(hq), 64'd2);
    chk("ignored start div lo", 64'(lq), 64'd14);
    chk("ignored start busy after", 64'(bus.busy), 64'd0);

    // Reset in cycle 10 of a mult that follows mthi
    bus.start = 1'b1; bus.op = MTHI; bus.a = 32'hAA;
    @(posedge clk); #1;
    chk("pre-abort mthi", 64'(bus.hi), 64'hAA);
    bus.op = MULT; bus.a = 32'd3; bus.b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort hi", 64'(bus.hi), 64'd0);
    chk("abort lo", 64'(bus.lo), 64'd0);
    chk("abort busy", 64'(bus.busy), 64'd0);
    dcnt = (bus.done === 1'b1) ? 1 : 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dcnt++;
    end
    chk("abort no done", 64'(dcnt), 64'd0);
    run_op("post-abort mult", MULT, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = '1;
        3: begin ra = 32'h8000_0000; rb = $urandom; end
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
      ref_op(rop, ra, rb, eh, el);
      run_op($sformatf("rand%0d op%0d a=%h b=%h", i, rop, ra, rb), rop, ra, rb, eh, el);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
